// File: rtl/msk_scan_ctrl_pkg.sv
// Shared definitions for the masked scan-chain controller: state encoding and
// a constant-function helper used to size the counters.
package msk_ctrl_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;
   localparam logic [1:0] ST_UNLOAD = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      LOAD   = ST_LOAD,
      RUN    = ST_RUN,
      UNLOAD = ST_UNLOAD
   } state_e;

   // Ceiling log2, never below 1 so a counter always has at least one bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/msk_scan_ctrl_if.sv
// Control/handshake bundle between the stream front-end, the scan chain and
// the scan controller. The controller takes the slave side.
interface msk_scan_ctrl_if #(
   parameter int CYCW = 8
);
   logic            start;
   logic [CYCW-1:0] cfg_ncycles;
   logic            abort;
   logic            in_valid;
   logic            in_ready;
   logic            out_valid;
   logic            out_ready;
   logic            reg_en;
   logic            scan_en;
   logic            busy;
   logic            done;

   modport slave (
      input  start, cfg_ncycles, abort, in_valid, out_ready,
      output in_ready, out_valid, reg_en, scan_en, busy, done
   );

   modport master (
      output start, cfg_ncycles, abort, in_valid, out_ready,
      input  in_ready, out_valid, reg_en, scan_en, busy, done
   );
endinterface

// File: rtl/msk_scan_ctrl_beat_cnt.sv
// Up-counter with synchronous clear (priority over increment) and a
// terminal-count flag that fires on the increment reaching limit_i.
module msk_beat_cnt #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         inc_i,
   input  logic [W-1:0] limit_i,
   output logic         tc_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = inc_i && (count_q == (limit_i - W'(1)));

endmodule

// File: rtl/msk_scan_ctrl.sv
// Sequencer for a chain of masked scan registers: serial load, N compute
// cycles, serial unload. Only control strobes are produced, never share data.
module msk_scan_ctrl
   import msk_ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CYCW  = 8
) (
   input logic             clk,
   input logic             rst_n,
   msk_scan_ctrl_if.slave  bus
);

   localparam int BW = clog2(DEPTH + 1);

   state_e          state_q;
   state_e          state_d;
   logic [CYCW-1:0] ncyc_q;
   logic [CYCW-1:0] ncyc_d;
   logic            done_q;
   logic            done_d;

   logic abortHit;
   logic beatInc;
   logic cycInc;
   logic cntClr;
   logic beatTc;
   logic cycTc;

   // Abort suppresses every chain strobe in the cycle it is seen.
   assign abortHit = bus.abort && (state_q != IDLE);
   assign beatInc  = !abortHit && (((state_q == LOAD) && bus.in_valid) ||
                                   ((state_q == UNLOAD) && bus.out_ready));
   assign cycInc   = !abortHit && (state_q == RUN);

   msk_beat_cnt #(.W(BW)) uBeatCnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (cntClr),
      .inc_i   (beatInc),
      .limit_i (BW'(DEPTH)),
      .tc_o    (beatTc)
   );

   msk_beat_cnt #(.W(CYCW)) uCycCnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (cntClr),
      .inc_i   (cycInc),
      .limit_i (ncyc_q),
      .tc_o    (cycTc)
   );

   always_comb begin
      state_d = state_q;
      ncyc_d  = ncyc_q;
      done_d  = 1'b0;
      cntClr  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = LOAD;
               ncyc_d  = bus.cfg_ncycles;
               cntClr  = 1'b1;
            end
         end
         LOAD: begin
            if (beatTc) begin
               state_d = (ncyc_q != '0) ? RUN : UNLOAD;
               cntClr  = 1'b1;
            end
         end
         RUN: begin
            if (cycTc) begin
               state_d = UNLOAD;
               cntClr  = 1'b1;
            end
         end
         UNLOAD: begin
            if (beatTc) begin
               state_d = IDLE;
               cntClr  = 1'b1;
               done_d  = 1'b1;
            end
         end
      endcase
      if (abortHit) begin
         state_d = IDLE;
         cntClr  = 1'b1;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ncyc_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ncyc_q  <= ncyc_d;
         done_q  <= done_d;
      end
   end

   // scan_en and busy decode straight from the state flops.
   assign bus.scan_en   = (state_q == LOAD) || (state_q == UNLOAD);
   assign bus.busy      = (state_q != IDLE);
   assign bus.in_ready  = (state_q == LOAD);
   assign bus.out_valid = (state_q == UNLOAD);
   assign bus.reg_en    = beatInc || cycInc;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_msk_scan_ctrl.sv
// Directed bench for msk_scan_ctrl: a DEPTH=4 instance with a behavioural
// scan-chain model, plus a DEPTH=1 instance for the full-range cycle count.
module tb_msk_scan_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   nCmp  = 0;
   int   nErr  = 0;

   always #5 clk = ~clk;

   msk_scan_ctrl_if #(.CYCW(8)) bus4 ();
   msk_scan_ctrl_if #(.CYCW(8)) bus1 ();

   msk_scan_ctrl #(.DEPTH(4), .CYCW(8)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   msk_scan_ctrl #(.DEPTH(1), .CYCW(8)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // Behavioural chain: shift on scan, otherwise each compute cycle adds one.
   logic [7:0] scanIn;
   logic [7:0] chain [4];
   logic [7:0] unloadQ [$];
   int         loadShifts;
   int         unloadShifts;

   always @(posedge clk) begin
      if (bus4.reg_en) begin
         if (bus4.scan_en) begin
            if (bus4.out_valid) begin
               unloadQ.push_back(chain[3]);
               unloadShifts++;
            end
            if (bus4.in_ready) loadShifts++;
            for (int i = 3; i > 0; i--) chain[i] <= chain[i-1];
            chain[0] <= scanIn;
         end else begin
            for (int i = 0; i < 4; i++) chain[i] <= chain[i] + 8'd1;
         end
      end
   end

   function automatic logic [5:0] obs4();
      return {bus4.busy, bus4.scan_en, bus4.reg_en, bus4.in_ready, bus4.out_valid, bus4.done};
   endfunction

   function automatic logic [5:0] obs1();
      return {bus1.busy, bus1.scan_en, bus1.reg_en, bus1.in_ready, bus1.out_valid, bus1.done};
   endfunction

   // Expected {busy,scan_en,reg_en,in_ready,out_valid,done} for a stall-free job started at t=0.
   function automatic logic [5:0] expJob(input int t, input int depth, input int n);
      if (t <= 0)                return 6'b000000;
      if (t <= depth)            return 6'b111100;
      if (t <= depth + n)        return 6'b101000;
      if (t <= 2 * depth + n)    return 6'b111010;
      if (t == 2 * depth + n + 1) return 6'b000001;
      return 6'b000000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic a, input logic iv,
                                input logic orr, input logic [7:0] cfg);
      bus4.start       = s;
      bus4.abort       = a;
      bus4.in_valid    = iv;
      bus4.out_ready   = orr;
      bus4.cfg_ncycles = cfg;
   endtask

   task automatic clearModel();
      unloadQ.delete();
      loadShifts   = 0;
      unloadShifts = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'd3);
      bus1.start = 1'b1; bus1.abort = 1'b0; bus1.in_valid = 1'b1;
      bus1.out_ready = 1'b1; bus1.cfg_ncycles = 8'd3;
      scanIn = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      nCmp++;
      if (obs4() !== 6'b000000) begin
         nErr++; $display("[TB] FAIL reset_d4 obs=%b exp=%b", obs4(), 6'b000000);
      end
      nCmp++;
      if (obs1() !== 6'b000000) begin
         nErr++; $display("[TB] FAIL reset_d1 obs=%b exp=%b", obs1(), 6'b000000);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      bus1.start = 1'b0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
      rst_n = 1'b1;
      #2;
      nCmp++;
      if (obs4() !== 6'b000000) begin
         nErr++; $display("[TB] FAIL post_reset obs=%b exp=%b", obs4(), 6'b000000);
      end
      tick();
   endtask

   task automatic test_basic();
      logic [7:0] words [4];
      words[0] = 8'h10; words[1] = 8'h20; words[2] = 8'h30; words[3] = 8'h40;
      clearModel();
      for (int t = 0; t <= 13; t++) begin
         applyStimulus(t == 0, 1'b0, 1'b1, 1'b1, 8'd3);
         scanIn = (t >= 1 && t <= 4) ? words[t-1] : 8'h00;
         #2;
         nCmp++;
         if (obs4() !== expJob(t, 4, 3)) begin
            nErr++; $display("[TB] FAIL basic t=%0d obs=%b exp=%b", t, obs4(), expJob(t, 4, 3));
         end
         tick();
      end
      nCmp++;
      if (unloadQ.size() !== 4) begin
         nErr++; $display("[TB] FAIL basic_count got=%0d exp=4", unloadQ.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            nCmp++;
            if (unloadQ[i] !== words[i] + 8'd3) begin
               nErr++; $display("[TB] FAIL basic_word%0d got=%h exp=%h", i, unloadQ[i], words[i] + 8'd3);
            end
         end
      end
   endtask

   task automatic test_stalls();
      logic [7:0] words [4];
      logic [5:0] expV;
      int         k;
      logic       iv;
      words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03; words[3] = 8'h04;
      clearModel();
      k = 0;
      for (int t = 0; t <= 16; t++) begin
         iv = !(t == 2 || t == 3);
         applyStimulus(t == 0, 1'b0, iv, !(t == 11), 8'd3);
         scanIn = words[(k < 4) ? k : 3];
         if (t == 0)                 expV = 6'b000000;
         else if (t == 1)            expV = 6'b111100;
         else if (t <= 3)            expV = 6'b110100;
         else if (t <= 6)            expV = 6'b111100;
         else if (t <= 9)            expV = 6'b101000;
         else if (t == 11)           expV = 6'b110010;
         else if (t <= 14)           expV = 6'b111010;
         else if (t == 15)           expV = 6'b000001;
         else                        expV = 6'b000000;
         #2;
         nCmp++;
         if (obs4() !== expV) begin
            nErr++; $display("[TB] FAIL stalls t=%0d obs=%b exp=%b", t, obs4(), expV);
         end
         if (t >= 1 && iv && k < 4) k++;
         tick();
      end
      nCmp++;
      if (loadShifts !== 4) begin
         nErr++; $display("[TB] FAIL stalls_load_shifts got=%0d exp=4", loadShifts);
      end
      nCmp++;
      if (unloadShifts !== 4) begin
         nErr++; $display("[TB] FAIL stalls_unload_shifts got=%0d exp=4", unloadShifts);
      end
      if (unloadQ.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            nCmp++;
            if (unloadQ[i] !== words[i] + 8'd3) begin
               nErr++; $display("[TB] FAIL stalls_word%0d got=%h exp=%h", i, unloadQ[i], words[i] + 8'd3);
            end
         end
      end
   endtask

   task automatic test_zero_cycles();
      logic [7:0] words [4];
      words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3; words[3] = 8'hD4;
      clearModel();
      for (int t = 0; t <= 10; t++) begin
         applyStimulus(t == 0, 1'b0, 1'b1, 1'b1, 8'd0);
         scanIn = (t >= 1 && t <= 4) ? words[t-1] : 8'hEE;
         #2;
         nCmp++;
         if (obs4() !== expJob(t, 4, 0)) begin
            nErr++; $display("[TB] FAIL zero t=%0d obs=%b exp=%b", t, obs4(), expJob(t, 4, 0));
         end
         tick();
      end
      nCmp++;
      if (unloadQ.size() !== 4) begin
         nErr++; $display("[TB] FAIL zero_count got=%0d exp=4", unloadQ.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            nCmp++;
            if (unloadQ[i] !== words[i]) begin
               nErr++; $display("[TB] FAIL zero_word%0d got=%h exp=%h", i, unloadQ[i], words[i]);
            end
         end
      end
   endtask

   task automatic test_abort();
      logic [5:0] expV;
      for (int t = 0; t <= 20; t++) begin
         applyStimulus(t == 0 || t == 7, t == 6, 1'b1, 1'b1, 8'd3);
         scanIn = 8'h55;
         if (t <= 5)      expV = expJob(t, 4, 3);
         else if (t == 6) expV = 6'b100000;
         else             expV = expJob(t - 7, 4, 3);
         #2;
         nCmp++;
         if (obs4() !== expV) begin
            nErr++; $display("[TB] FAIL abort t=%0d obs=%b exp=%b", t, obs4(), expV);
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      for (int t = 0; t <= 6; t++) begin
         applyStimulus(t == 0, 1'b0, 1'b1, 1'b1, 8'd0);
         #2;
         nCmp++;
         if (obs4() !== expJob(t, 4, 0)) begin
            nErr++; $display("[TB] FAIL areset_pre t=%0d obs=%b exp=%b", t, obs4(), expJob(t, 4, 0));
         end
         if (t < 6) tick();
      end
      #1 rst_n = 1'b0;
      #1;
      nCmp++;
      if (obs4() !== 6'b000000) begin
         nErr++; $display("[TB] FAIL areset_immediate obs=%b exp=%b", obs4(), 6'b000000);
      end
      tick();
      nCmp++;
      if (obs4() !== 6'b000000) begin
         nErr++; $display("[TB] FAIL areset_held obs=%b exp=%b", obs4(), 6'b000000);
      end
      rst_n = 1'b1;
      #2;
      nCmp++;
      if (obs4() !== 6'b000000) begin
         nErr++; $display("[TB] FAIL areset_release obs=%b exp=%b", obs4(), 6'b000000);
      end
      tick();
      for (int u = 0; u <= 13; u++) begin
         applyStimulus(u == 0 || u == 2 || u == 6 || u == 10, 1'b0, 1'b1, 1'b1, 8'd3);
         #2;
         nCmp++;
         if (obs4() !== expJob(u, 4, 3)) begin
            nErr++; $display("[TB] FAIL areset_job u=%0d obs=%b exp=%b", u, obs4(), expJob(u, 4, 3));
         end
         tick();
      end
   endtask

   task automatic test_depth1();
      int runCycles = 0;
      int doneCnt   = 0;
      bus1.abort = 1'b0; bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
      bus1.cfg_ncycles = 8'd255;
      for (int t = 0; t <= 259; t++) begin
         bus1.start = (t == 0);
         #2;
         nCmp++;
         if (obs1() !== expJob(t, 1, 255)) begin
            nErr++; $display("[TB] FAIL depth1 t=%0d obs=%b exp=%b", t, obs1(), expJob(t, 1, 255));
         end
         if (bus1.busy && !bus1.scan_en) runCycles++;
         if (bus1.done) doneCnt++;
         tick();
      end
      nCmp++;
      if (runCycles !== 255) begin
         nErr++; $display("[TB] FAIL depth1_run_cycles got=%0d exp=255", runCycles);
      end
      nCmp++;
      if (doneCnt !== 1) begin
         nErr++; $display("[TB] FAIL depth1_done_count got=%0d exp=1", doneCnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stalls();
      test_zero_cycles();
      test_abort();
      test_async_reset();
      test_depth1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule

// File: doc/msk_scan_ctrl.md
Name: msk_scan_ctrl

Overview:
Control sequencer for a chain of DEPTH masked scan registers (MSKscanReg stages, each count*d bits) sharing one en/scan_en pair. It runs one job per start: serial load of DEPTH words, then N compute cycles, then serial unload of DEPTH words. It drives only non-sensitive control signals (enable, scan select, handshakes) and never touches share data. Sits between a stream front-end and a masked core whose state lives in the scan chain.

Parameters:
DEPTH, 4, number of scan-chain stages (words shifted per load/unload); must be >= 1.
CYCW, 8, width of compute-cycle count cfg_ncycles.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  job request; sampled only in IDLE.
cfg_ncycles  input  CYCW  compute cycles for the job; latched when start is accepted.
abort  input  1  synchronous abort; returns to IDLE next cycle.
in_valid  input  1  a scan-in word is present on the chain's scan input.
in_ready  output  1  controller accepts the scan-in word this cycle.
out_valid  output  1  last chain stage holds a valid result word.
out_ready  input  1  consumer takes the result word.
reg_en  output  1  to every stage's en.
scan_en  output  1  to every stage's scan_en (1 = shift, 0 = capture in_d).
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse when a job completes normally.

Behaviour:
- States: IDLE, LOAD, RUN, UNLOAD. 2-bit state register; beat counter of clog2(DEPTH+1) bits; cycle counter of CYCW bits.
- Reset (async, rst_n=0): state=IDLE, counters=0. All outputs 0 while in reset and on the first cycle after it. Chain contents are not cleared; the datapath has no reset.
- Decode: scan_en and busy come from state flops only (glitch-free). in_ready=(state==LOAD). out_valid=(state==UNLOAD). reg_en is combinational: LOAD: in_valid; RUN: 1; UNLOAD: out_ready; IDLE: 0.
- IDLE: scan_en=0, reg_en=0. If start=1, latch cfg_ncycles into ncyc, clear beat count, go to LOAD. done is never asserted in the same cycle as start acceptance.
- LOAD: scan_en=1. Each cycle with in_valid=1 is one beat: shift and increment the count. On the DEPTH-th beat, go to RUN if ncyc!=0, else go directly to UNLOAD. A cycle with in_valid=0 is a stall: no shift, no count change.
- RUN: scan_en=0, reg_en=1 for exactly ncyc consecutive cycles, counted from the first RUN cycle. After the ncyc-th cycle, go to UNLOAD with the beat count cleared.
- UNLOAD: scan_en=1, out_valid=1. Each cycle with out_ready=1 is one beat: shift and count. After the DEPTH-th beat, go to IDLE and assert done for exactly the next cycle (done is registered, high in the first IDLE cycle).
- start outside IDLE is ignored, with no queuing.
- abort=1 in LOAD/RUN/UNLOAD: reg_en forced to 0 that cycle, next state IDLE, counters cleared, done is not asserted. abort in IDLE has no effect. If abort and start are both high in IDLE, start wins.
- Boundary cases:
  - DEPTH=1: single-beat load and unload.
  - ncyc = 2^CYCW-1: full counter range, no wrap.
  - in_valid held high across the LOAD->RUN transition: not consumed (in_ready=0 in RUN).
  - Minimum job (ncyc=0, no stalls): 2*DEPTH cycles of busy.
- Async reset mid-job: immediate return to IDLE, no done.

Decomposition:
- Shared package msk_ctrl_pkg holds:
  - state encoding localparams (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, UNLOAD=2'd3);
  - a clog2 helper function for counter widths.
- One sub-module: msk_beat_cnt, a parameterised up-counter with clear, increment and a terminal-count flag (count==LIMIT-1 && inc). It is instantiated twice: once for beats (LIMIT=DEPTH) and once for compute cycles (runtime limit ncyc).
- The FSM and output decode stay in msk_scan_ctrl.

Test Plan:
1. Setup DEPTH=4, cfg_ncycles=3, in_valid and out_ready held 1, start pulsed at t0 -> LOAD t1..t4 (scan_en=1, reg_en=1); RUN t5..t7 (scan_en=0, reg_en=1); UNLOAD t8..t11; done=1 at t12 only; busy t1..t11.
2. Same job with in_valid low on the 2nd and 3rd LOAD cycles and out_ready low for 1 UNLOAD cycle -> reg_en low on exactly those cycles; phases stretch by 2 and 1 cycles; exactly 4 shifts per phase; done at t15.
3. cfg_ncycles=0 -> no RUN cycle, UNLOAD directly after the 4th load beat, scan_en never 0 while busy; a golden chain model shows the unloaded words equal the loaded words in FIFO order.
4. abort at the 2nd RUN cycle -> reg_en=0 that cycle, IDLE next, no done; a new start is accepted the following cycle and completes normally.
5. rst_n low mid-UNLOAD (asynchronous, between clock edges) -> all outputs 0 immediately, state IDLE; start after release runs a full job; start pulsed during a busy job is ignored.
6. DEPTH=1, cfg_ncycles=255 (CYCW=8) -> exactly 255 RUN cycles, 1 load beat, 1 unload beat, done once.
